// File: rtl/core_data_mem_ctrl.sv
// Data-side memory controller for the core load/store port.
// Accepts one transaction at a time over req/gnt/rvalid and drives a
// synchronous single-port SRAM. Optional wait states are inserted before the
// access. Addresses beyond the SRAM return an error response instead.
module core_data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BE_WIDTH    = 4,
    parameter int SRAM_AW     = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_wr_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    output logic [BE_WIDTH-1:0]   sram_be_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    // Request captured at the grant edge; oor marks an out-of-range address.
    typedef struct packed {
        logic [SRAM_AW-1:0]    addr;
        logic                  wr;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  oor;
    } req_t;

    // Last count value before leaving WAIT (only meaningful when WAIT_STATES > 0).
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t     state, state_nxt;
    req_t       req_q;
    logic [3:0] wait_cnt;
    logic       addr_oor;

    // Byte-offset bits are ignored: the SRAM is word addressed with byte enables.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^data_addr_i[1:0];

    // No aliasing: any bit above the SRAM window flags an error.
    assign addr_oor = (data_addr_i[ADDR_WIDTH-1:SRAM_AW+2] != '0);

    // State register; async reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Wait counter: zero outside WAIT so it restarts at 0 on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 4'd1;
        else                     wait_cnt <= '0;
    end

    // Capture the request on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (state == IDLE && data_req_i) begin
            req_q.addr  <= data_addr_i[SRAM_AW+1:2];
            req_q.wr    <= data_wr_i;
            req_q.be    <= data_be_i;
            req_q.wdata <= data_wdata_i;
            req_q.oor   <= addr_oor;
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_nxt     = state;
        data_gnt_o    = 1'b0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        sram_ce_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_be_o     = '0;
        sram_wdata_o  = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so no grant is seen while reset is held.
                data_gnt_o = data_req_i & rst_n;
                if (data_req_i) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!req_q.oor) begin
                    sram_ce_o    = 1'b1;
                    sram_we_o    = req_q.wr;
                    sram_addr_o  = req_q.addr;
                    sram_be_o    = req_q.be;
                    sram_wdata_o = req_q.wdata;
                end
                state_nxt = RESP;
            end
            RESP: begin
                data_rvalid_o = 1'b1;
                data_err_o    = req_q.oor;
                if (!req_q.oor && !req_q.wr) data_rdata_o = sram_rdata_i;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_data_mem_ctrl.sv
// Bench for core_data_mem_ctrl: one instance with no wait states and one with
// three, each backed by a behavioural 1-cycle-latency SRAM.
module tb_core_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst0_n, rst3_n;
    logic        req, sel, mem_init;
    logic [31:0] addr, wdata;
    logic        wr;
    logic [3:0]  be;

    logic        req0, req3;
    logic        gnt0, rvalid0, err0, ce0, we0;
    logic        gnt3, rvalid3, err3, ce3, we3;
    logic [31:0] rdata0, wdata0, rd0, rdata3, wdata3, rd3;
    logic [11:0] saddr0, saddr3;
    logic [3:0]  be0, be3;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem3 [0:4095];

    // Selected-instance view used by the checking task.
    logic        gnt, rvalid, err, ce, we;
    logic [31:0] rdata, swdata;
    logic [11:0] saddr;
    logic [3:0]  sbe;

    int tests = 0;
    int fails = 0;
    int rv3_cnt = 0;

    always #5 clk = ~clk;

    assign req0 = req & ~sel;
    assign req3 = req & sel;

    assign gnt    = sel ? gnt3    : gnt0;
    assign rvalid = sel ? rvalid3 : rvalid0;
    assign err    = sel ? err3    : err0;
    assign ce     = sel ? ce3     : ce0;
    assign we     = sel ? we3     : we0;
    assign rdata  = sel ? rdata3  : rdata0;
    assign swdata = sel ? wdata3  : wdata0;
    assign saddr  = sel ? saddr3  : saddr0;
    assign sbe    = sel ? be3     : be0;

    core_data_mem_ctrl #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst0_n),
        .data_req_i(req0), .data_addr_i(addr), .data_wr_i(wr), .data_be_i(be),
        .data_wdata_i(wdata), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
        .data_rdata_o(rdata0), .data_err_o(err0), .sram_ce_o(ce0), .sram_we_o(we0),
        .sram_addr_o(saddr0), .sram_be_o(be0), .sram_wdata_o(wdata0), .sram_rdata_i(rd0)
    );

    core_data_mem_ctrl #(.WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst3_n),
        .data_req_i(req3), .data_addr_i(addr), .data_wr_i(wr), .data_be_i(be),
        .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
        .data_rdata_o(rdata3), .data_err_o(err3), .sram_ce_o(ce3), .sram_we_o(we3),
        .sram_addr_o(saddr3), .sram_be_o(be3), .sram_wdata_o(wdata3), .sram_rdata_i(rd3)
    );

    // Behavioural SRAMs: byte-masked write, registered read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem0[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
            mem3[16] <= 32'h1234_5678;
            mem3[17] <= 32'hCAFE_F00D;
        end else begin
            if (ce0) begin
                if (we0) begin
                    for (int b = 0; b < 4; b++)
                        if (be0[b]) mem0[saddr0][8*b +: 8] <= wdata0[8*b +: 8];
                end else rd0 <= mem0[saddr0];
            end
            if (ce3) begin
                if (we3) begin
                    for (int b = 0; b < 4; b++)
                        if (be3[b]) mem3[saddr3][8*b +: 8] <= wdata3[8*b +: 8];
                end else rd3 <= mem3[saddr3];
            end
        end
    end

    // Count responses from the wait-state instance.
    always @(negedge clk) if (rvalid3) rv3_cnt <= rv3_cnt + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Run one transaction from an IDLE negedge; returns at the following
    // IDLE negedge. With hold=1 the request stays asserted afterwards.
    task automatic txn(input vec_t v, input int w, input bit hold);
        logic [50:0] exp_acc;
        req = 1'b1; addr = v.addr; wr = v.wr; be = v.be; wdata = v.wdata;
        #1 chk("grant", 64'(gnt), 64'd1);
        @(negedge clk);
        for (int i = 0; i < w; i++) begin
            chk("wait_quiet", 64'({gnt, ce, rvalid}), 64'd0);
            @(negedge clk);
        end
        exp_acc = v.exp_err ? 51'd0 : {1'b0, 1'b1, v.wr, v.addr[13:2], v.be, v.wdata};
        chk("access", 64'({gnt, ce, we, saddr, sbe, swdata}), 64'(exp_acc));
        @(negedge clk);
        chk("resp", 64'({gnt, ce, rvalid, err, rdata}),
            64'({1'b0, 1'b0, 1'b1, v.exp_err, v.exp_rdata}));
        if (!hold) req = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs [11];
    vec_t v;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0040, 4'h2, 32'h0000_AB00, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0041, 4'hF, 32'h0,         32'hDEAD_ABEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0044, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0044, 4'hF, 32'h0,         32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,         32'h0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         32'h0, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0000, 4'hF, 32'h0000_0001, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_3FFC, 4'h5, 32'hA5A5_A5A5, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_3FFC, 4'hF, 32'h0,         32'h00A5_00A5, 1'b0};

        rst0_n = 1'b0; rst3_n = 1'b0; mem_init = 1'b1;
        sel = 1'b0; req = 1'b1; addr = 32'h40; wr = 1'b0; be = 4'hF; wdata = 32'h0;

        // Reset held with a pending request: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outs", 64'({gnt0, rvalid0, ce0, we0, err0, rdata0}), 64'd0);
        end
        mem_init = 1'b0;
        rst0_n = 1'b1; rst3_n = 1'b1;
        #1 chk("first_grant", 64'(gnt0), 64'd1);
        req = 1'b0;
        @(negedge clk);

        // Zero-wait-state instance: directed vectors.
        for (int i = 0; i < 11; i++) txn(vecs[i], 0, 1'b0);

        // Three wait states: load 0x44, request held across the whole transaction.
        sel = 1'b1;
        @(negedge clk);
        v = '{1'b0, 32'h0000_0044, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0};
        txn(v, 3, 1'b1);
        chk("w3_next_grant", 64'(gnt3), 64'd1);
        req = 1'b0;
        @(negedge clk);

        // Async reset while in WAIT: nothing may come back for this request.
        req = 1'b1; addr = 32'h40; wr = 1'b0; be = 4'hF; wdata = 32'h0;
        #1 chk("w3_rst_grant", 64'(gnt3), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst3_n = 1'b0;
        #1 chk("async_rst_outs", 64'({gnt3, ce3, rvalid3, err3}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_held_quiet", 64'({gnt3, ce3, rvalid3}), 64'd0);
        end
        req = 1'b0;
        rst3_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'({ce3, rvalid3}), 64'd0);
        end

        v = '{1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h1234_5678, 1'b0};
        txn(v, 3, 1'b0);
        @(negedge clk);
        chk("w3_rvalid_count", 64'(rv3_cnt), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
